// File: rtl/gpif_pkg.sv
// ============================================================================
//  Module      : gpif_pkg
//  Description : Shared types and constants for the GPIF-II slave-FIFO
//                read master (state encoding, thread addresses, idle values).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpif_pkg;

    // Read-master states; encoding is explicit so waveforms stay stable.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_SETUP   = 3'd2,
        ST_BURST   = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_SINGLE  = 3'd5,
        ST_SWAIT   = 3'd6,
        ST_RELEASE = 3'd7
    } state_e;

    // SL_AD thread selections.
    localparam logic [1:0] ADDR_U2F  = 2'b11;
    localparam logic [1:0] ADDR_F2U  = 2'b00;

    // Values driven on the slave-FIFO pins while the bus is not owned.
    localparam logic [1:0] ADDR_IDLE   = 2'b00;
    localparam logic       CTRL_N_IDLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/gpif_rd_capture.sv
// ============================================================================
//  Module      : gpif_rd_capture
//  Description : Tracks in-flight slave-FIFO reads with a RD_LATENCY-deep
//                valid pipeline, captures SL_DT on arrival and presents one
//                local FIFO write per read. Flags writes made into a full FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpif_rd_capture
    import gpif_pkg::*;
#(
    parameter int WIDTH_DT   = 32,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_AW    = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                rd_issue_i,
    input  logic [WIDTH_DT-1:0] sl_dt_i,
    input  logic [FIFO_AW:0]    fifo_room_i,
    output logic                fifo_wr_en_o,
    output logic [WIDTH_DT-1:0] fifo_wr_dt_o,
    output logic                err_o
);

    logic [RD_LATENCY-1:0] vld_q;
    logic                  wr_en_q;
    logic [WIDTH_DT-1:0]   wr_dt_q;
    logic                  err_q;

    // Age each issued read; when it reaches the data latency, grab SL_DT and
    // write it. Reset clears the pipeline so in-flight reads are dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            vld_q   <= '0;
            wr_en_q <= 1'b0;
            wr_dt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            vld_q[0] <= rd_issue_i;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            wr_en_q <= vld_q[RD_LATENCY-1];
            if (vld_q[RD_LATENCY-1]) begin
                wr_dt_q <= sl_dt_i;
            end
            if (wr_en_q && (fifo_room_i == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fifo_wr_en_o = wr_en_q;
    assign fifo_wr_dt_o = wr_dt_q;
    assign err_o        = err_q;

endmodule

`default_nettype wire

// File: rtl/gpif_u2f_rd.sv
// ============================================================================
//  Module      : gpif_u2f_rd
//  Description : GPIF-II slave-FIFO read master for the host-to-FPGA thread.
//                Arbitrates for the SL_* bus, issues flag-paced bursts or
//                single reads and writes every returned word once into the
//                local U2F FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpif_u2f_rd
    import gpif_pkg::*;
#(
    parameter int         WIDTH_DT      = 32,
    parameter int         RD_LATENCY    = 2,
    parameter int         FLAG_LATENCY  = 3,
    parameter int         NUM_WATERMARK = 4,
    parameter int         MAX_BURST     = 256,
    parameter int         FIFO_AW       = 10,
    parameter logic [1:0] ADDR_U2F      = gpif_pkg::ADDR_U2F
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_n_i,
    input  logic                enable_i,
    output logic                bus_req_o,
    input  logic                bus_gnt_i,
    output logic                sl_cs_n_o,
    output logic                sl_oe_n_o,
    output logic                sl_rd_n_o,
    output logic [1:0]          sl_ad_o,
    input  logic                sl_flaga_i,
    input  logic                sl_flagb_i,
    input  logic [WIDTH_DT-1:0] sl_dt_i,
    input  logic [FIFO_AW:0]    fifo_room_i,
    output logic                fifo_wr_en_o,
    output logic [WIDTH_DT-1:0] fifo_wr_dt_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam int WW = $clog2(RD_LATENCY + FLAG_LATENCY + 1);

    localparam logic [CW-1:0]    C_MAX_BURST   = CW'(MAX_BURST);
    localparam logic [WW-1:0]    C_DRAIN_LAST  = WW'(RD_LATENCY);
    localparam logic [WW-1:0]    C_SWAIT_LAST  = WW'(RD_LATENCY + FLAG_LATENCY - 1);
    localparam logic [FIFO_AW:0] C_ROOM_BURST  = (FIFO_AW+1)'(MAX_BURST + RD_LATENCY);
    localparam logic [FIFO_AW:0] C_ROOM_SINGLE = (FIFO_AW+1)'(1 + RD_LATENCY);

    // The watermark must cover every read still in flight when FLAGB drops,
    // otherwise a burst can over-read an emptying thread.
    if (NUM_WATERMARK <= FLAG_LATENCY + RD_LATENCY) begin : g_cfg_check
        $error("gpif_u2f_rd: NUM_WATERMARK must exceed FLAG_LATENCY + RD_LATENCY");
    end

    state_e         state_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic [WW-1:0]  wait_q;
    logic           bus_req_q;
    logic           cs_n_q;
    logic           oe_n_q;
    logic           rd_n_q;
    logic [1:0]     ad_q;
    logic           busy_q;
    logic           rd_issue;

    // Reads issued so far in this tenure, including the one in flight now.
    always_comb begin
        count_d = count_q + CW'(1);
    end

    // Tenure sequencer; all pin controls are registered alongside the state.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            wait_q    <= '0;
            bus_req_q <= 1'b0;
            cs_n_q    <= CTRL_N_IDLE;
            oe_n_q    <= CTRL_N_IDLE;
            rd_n_q    <= CTRL_N_IDLE;
            ad_q      <= ADDR_IDLE;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable_i && sl_flaga_i && (fifo_room_i >= C_ROOM_BURST)) begin
                        state_q   <= ST_REQ;
                        bus_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt_i) begin
                        state_q <= ST_SETUP;
                        cs_n_q  <= 1'b0;
                        oe_n_q  <= 1'b0;
                        ad_q    <= ADDR_U2F;
                    end
                end
                ST_SETUP: begin
                    rd_n_q  <= 1'b0;
                    state_q <= sl_flagb_i ? ST_BURST : ST_SINGLE;
                end
                ST_BURST: begin
                    count_q <= count_d;
                    if ((count_d == C_MAX_BURST) || !sl_flagb_i || !enable_i) begin
                        state_q <= ST_DRAIN;
                        rd_n_q  <= 1'b1;
                        wait_q  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (wait_q == C_DRAIN_LAST) begin
                        state_q   <= ST_RELEASE;
                        cs_n_q    <= CTRL_N_IDLE;
                        oe_n_q    <= CTRL_N_IDLE;
                        ad_q      <= ADDR_IDLE;
                        bus_req_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                ST_SINGLE: begin
                    count_q <= count_d;
                    rd_n_q  <= 1'b1;
                    wait_q  <= '0;
                    state_q <= ST_SWAIT;
                end
                ST_SWAIT: begin
                    // Wait until the flags reflect the last read before deciding.
                    if (wait_q == C_SWAIT_LAST) begin
                        if (sl_flaga_i && enable_i && (count_q < C_MAX_BURST) &&
                            (fifo_room_i >= C_ROOM_SINGLE)) begin
                            state_q <= ST_SINGLE;
                            rd_n_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_RELEASE;
                            cs_n_q    <= CTRL_N_IDLE;
                            oe_n_q    <= CTRL_N_IDLE;
                            ad_q      <= ADDR_IDLE;
                            bus_req_q <= 1'b0;
                        end
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_issue = ~rd_n_q;

    gpif_rd_capture #(
        .WIDTH_DT   (WIDTH_DT),
        .RD_LATENCY (RD_LATENCY),
        .FIFO_AW    (FIFO_AW)
    ) u_capture (
        .clk_i        (sys_clk_i),
        .rst_n_i      (sys_rst_n_i),
        .rd_issue_i   (rd_issue),
        .sl_dt_i      (sl_dt_i),
        .fifo_room_i  (fifo_room_i),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_wr_dt_o (fifo_wr_dt_o),
        .err_o        (err_o)
    );

    assign bus_req_o = bus_req_q;
    assign sl_cs_n_o = cs_n_q;
    assign sl_oe_n_o = oe_n_q;
    assign sl_rd_n_o = rd_n_q;
    assign sl_ad_o   = ad_q;
    assign busy_o    = busy_q;

endmodule

`default_nettype wire
